// File: rtl/multi_ctrl_pipe_pkg.sv
// multi_ctrl_pipe_pkg: shared sizing constants for the multi-destination forward/backward pipes.
package multi_ctrl_pipe_pkg;
    localparam int DEST_N_DEF = 2;
    localparam int DEPTH      = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;
endpackage

// File: rtl/multi_ctrl_bwd_pipe.sv
// multi_ctrl_bwd_pipe: 2-entry in-order multi-destination buffer with registered master ready.
// MULTI_CTRL_BWD_PIPE_PARTIAL_ACK_EN lets each destination acknowledge the head independently.
module multi_ctrl_bwd_pipe
    import multi_ctrl_pipe_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEST_N = DEST_N_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DEST_N-1:0] f_valid_in,
    input  logic [DATA_W-1:0] f_data_in,
    output logic [DEST_N-1:0] f_ready_out,
    output logic [DEST_N-1:0] b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    input  logic [DEST_N-1:0] b_ready_in
);
    logic [DEST_N-1:0] mask_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              rdy_q;
    logic [DEST_N-1:0] head_mask, clr, head_nxt;
    logic              non_empty, push, pop;

    assign non_empty   = cnt_q != '0;
    assign head_mask   = mask_q[rd_ptr];
    assign b_valid_out = non_empty ? head_mask : '0;
    assign b_data_out  = data_q[rd_ptr];
    assign f_ready_out = {DEST_N{rdy_q}};

    genvar i;
    generate
        for (i = 0; i < DEST_N; i++) begin : g_pend
`ifdef MULTI_CTRL_BWD_PIPE_PARTIAL_ACK_EN
            assign clr[i] = b_valid_out[i] & b_ready_in[i];
`else
            // all-or-nothing: a bit clears only when every pending destination accepts together
            assign clr[i] = b_valid_out[i] & ((b_ready_in & b_valid_out) == b_valid_out);
`endif
        end
    endgenerate

    assign head_nxt = head_mask & ~clr;
    assign push     = (|f_valid_in) & rdy_q;
    assign pop      = non_empty & ~(|head_nxt);
    assign cnt_nxt  = cnt_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                mask_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            if (non_empty)
                mask_q[rd_ptr] <= head_nxt;
            if (push) begin
                mask_q[wr_ptr] <= f_valid_in;
                data_q[wr_ptr] <= f_data_in;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            cnt_q <= cnt_nxt;
            rdy_q <= cnt_nxt < CNT_W'(DEPTH);
        end
    end
endmodule

// File: tb/tb_multi_ctrl_bwd_pipe.sv
// tb_multi_ctrl_bwd_pipe: table-driven directed bench for multi_ctrl_bwd_pipe.
module tb_multi_ctrl_bwd_pipe;
    typedef struct packed {
        logic [1:0] fv;
        logic [7:0] fd;
        logic [1:0] br;
        logic [1:0] frdy;
        logic [1:0] bv;
        logic [7:0] bd;
        logic       bdc;
    } vec_t;

    localparam int NV = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] f_valid_in = '0;
    logic [7:0] f_data_in = '0;
    logic [1:0] f_ready_out;
    logic [1:0] b_valid_out;
    logic [7:0] b_data_out;
    logic [1:0] b_ready_in = '0;
    int         tests = 0;
    int         fails = 0;
    vec_t       vecs [NV];

    multi_ctrl_bwd_pipe #(.DATA_W(8), .DEST_N(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .f_valid_in(f_valid_in),
        .f_data_in(f_data_in),
        .f_ready_out(f_ready_out),
        .b_valid_out(b_valid_out),
        .b_data_out(b_data_out),
        .b_ready_in(b_ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // fv, fd, br | frdy, bv, bd, check bd
        vecs[0]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b00, 8'h00, 1'b1};
        vecs[1]  = '{2'b11, 8'hA5, 2'b11, 2'b11, 2'b00, 8'h00, 1'b0};
        vecs[2]  = '{2'b00, 8'h00, 2'b11, 2'b11, 2'b11, 8'hA5, 1'b1};
        vecs[3]  = '{2'b00, 8'hFF, 2'b00, 2'b11, 2'b00, 8'h00, 1'b0};
        vecs[4]  = '{2'b01, 8'h01, 2'b00, 2'b11, 2'b00, 8'h00, 1'b0};
        vecs[5]  = '{2'b10, 8'h02, 2'b00, 2'b11, 2'b01, 8'h01, 1'b1};
        vecs[6]  = '{2'b11, 8'h03, 2'b00, 2'b00, 2'b01, 8'h01, 1'b1};
        vecs[7]  = '{2'b11, 8'h03, 2'b11, 2'b00, 2'b01, 8'h01, 1'b1};
        vecs[8]  = '{2'b11, 8'h03, 2'b11, 2'b11, 2'b10, 8'h02, 1'b1};
        vecs[9]  = '{2'b00, 8'h00, 2'b11, 2'b11, 2'b11, 8'h03, 1'b1};
        vecs[10] = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b00, 8'h00, 1'b0};
        vecs[11] = '{2'b11, 8'hB6, 2'b00, 2'b11, 2'b00, 8'h00, 1'b0};
        vecs[12] = '{2'b00, 8'h00, 2'b01, 2'b11, 2'b11, 8'hB6, 1'b1};
`ifdef MULTI_CTRL_BWD_PIPE_PARTIAL_ACK_EN
        vecs[13] = '{2'b00, 8'h00, 2'b10, 2'b11, 2'b10, 8'hB6, 1'b1};
        vecs[14] = '{2'b00, 8'h00, 2'b11, 2'b11, 2'b00, 8'h00, 1'b0};
`else
        vecs[13] = '{2'b00, 8'h00, 2'b10, 2'b11, 2'b11, 8'hB6, 1'b1};
        vecs[14] = '{2'b00, 8'h00, 2'b11, 2'b11, 2'b11, 8'hB6, 1'b1};
`endif
        vecs[15] = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b00, 8'h00, 1'b0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d f_ready_out", k), {6'b0, f_ready_out}, {6'b0, vecs[k].frdy});
            chk($sformatf("v%0d b_valid_out", k), {6'b0, b_valid_out}, {6'b0, vecs[k].bv});
            if (vecs[k].bdc)
                chk($sformatf("v%0d b_data_out", k), b_data_out, vecs[k].bd);
            f_valid_in = vecs[k].fv;
            f_data_in  = vecs[k].fd;
            b_ready_in = vecs[k].br;
        end

        // fill both entries, then reset in the middle of delivery
        @(negedge clk);
        f_valid_in = 2'b01; f_data_in = 8'h11; b_ready_in = 2'b00;
        @(negedge clk);
        f_valid_in = 2'b10; f_data_in = 8'h22;
        @(negedge clk);
        f_valid_in = 2'b00;
        chk("full f_ready_out", {6'b0, f_ready_out}, 8'h00);
        chk("full head data", b_data_out, 8'h11);
        b_ready_in = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        chk("rst b_valid_out", {6'b0, b_valid_out}, 8'h00);
        chk("rst f_ready_out", {6'b0, f_ready_out}, 8'h03);
        chk("rst b_data_out", b_data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        b_ready_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst%0d b_valid_out", k), {6'b0, b_valid_out}, 8'h00);
            chk($sformatf("post-rst%0d f_ready_out", k), {6'b0, f_ready_out}, 8'h03);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_ctrl_bwd_pipe.md
MULTI_CTRL_BWD_PIPE -- requirements
Module: multi_ctrl_bwd_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 256, payload width in bits.
REQ-002 SHALL have parameter DEST_N, default 2, number of destinations (width of every mask port).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port f_valid_in  input  DEST_N  master destination mask; nonzero marks a valid beat.
REQ-006 SHALL have port f_data_in  input  DATA_W  master payload.
REQ-007 SHALL have port f_ready_out  output  DEST_N  master ready; all bits identical.
REQ-008 SHALL have port b_valid_out  output  DEST_N  pending-destination mask of the head entry.
REQ-009 SHALL have port b_data_out  output  DATA_W  head-entry payload.
REQ-010 SHALL have port b_ready_in  input  DEST_N  per-destination slave ready.

Function
REQ-011 SHALL be a 2-entry in-order buffer; f_ready_out SHALL be a registered function of occupancy only, with no combinational path from b_ready_in.
REQ-012 SHALL drive f_ready_out all-ones when occupancy < 2 and all-zeros when occupancy == 2.
REQ-013 SHALL push when |f_valid_in and f_ready_out[0]; the stored mask is f_valid_in and the stored data is f_data_in.
REQ-014 SHALL ignore f_data_in when f_valid_in == 0; a zero mask is never stored.
REQ-015 SHALL present a beat pushed at edge N on b_valid_out/b_data_out after edge N when the buffer was empty (1-cycle latency), else after all older entries retire.
REQ-016 SHALL drive b_valid_out = 0 when empty; b_data_out holds the last head value and is don't-care while empty.
REQ-017 SHALL clear pending bit i of the head at an edge where b_valid_out[i] & b_ready_in[i] (behaviour per REQ-027/028).
REQ-018 SHALL retire (pop) the head at the edge its pending mask becomes zero; the next entry appears the following cycle.
REQ-019 SHALL keep occupancy unchanged on simultaneous push and pop, and keep FIFO order.
REQ-020 SHALL never push when full; a valid master beat is held off, not dropped.
REQ-021 SHALL use 1-bit wrapping read/write pointers and a 2-bit occupancy counter (0..2).

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear pointers, occupancy, stored masks and stored data.
REQ-023 SHALL drive after reset: f_ready_out all-ones, b_valid_out 0, b_data_out 0.
REQ-024 SHALL discard all buffered and partially delivered entries on reset mid-operation; no beat reappears after reset release.

Configuration
REQ-025 SHALL use macro MULTI_CTRL_BWD_PIPE_PARTIAL_ACK_EN.
REQ-026 SHALL leave REQ-011..REQ-024 identical in both builds except pending-bit clearing.
REQ-027 SHALL, with the macro defined, clear each pending bit independently as its destination accepts (partial acknowledge across cycles).
REQ-028 SHALL, without the macro, clear the whole head mask only in a cycle where (b_ready_in & b_valid_out) == b_valid_out; otherwise no bit clears.

Structure
REQ-029 SHALL place DEST_N default, pointer width and occupancy-count width constants in shared package multi_ctrl_pipe_pkg, also usable by the forward pipe.
REQ-030 SHALL instantiate no sub-module; per-destination pending logic is a generate loop inside the block.

Verification
REQ-031 Empty buffer, push mask 2'b11 data 0xA5, b_ready_in 2'b11 -> next cycle b_valid_out 2'b11, b_data_out 0xA5; popped at following edge; f_ready_out stays 2'b11.
REQ-032 Push 0x1 (mask 01), 0x2 (mask 10), 0x3 (mask 11) back-to-back with b_ready_in 0 -> f_ready_out drops to 0 after second push; 0x3 held; releasing b_ready_in 2'b11 drains 0x1, 0x2, 0x3 in order.
REQ-033 PARTIAL_ACK_EN defined, head mask 11, b_ready_in 01 then 10 -> b_valid_out 11, 10, then head retires; second destination never sees a repeated beat.
REQ-034 Macro undefined, same stimulus -> b_valid_out stays 11 in both cycles; retires only when b_ready_in 11.
REQ-035 Occupancy 1, simultaneous push and head retire -> occupancy stays 1, new beat at head next cycle, f_ready_out never deasserts.
REQ-036 Two entries buffered, rst_n pulsed low mid-transfer -> b_valid_out 0 and f_ready_out 2'b11 immediately; no old data after release.
